// File: rtl/my_shift_arbiter_pkg.sv
// Shared constants, op/state encodings and bit-reversal helper for the shift arbiter.
package my_shift_arbiter_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    // Op encodings; 2'b11 is treated as a left shift.
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        RESP  = 2'b10
    } state_t;

    // Mirror a word end-for-end so a left shift acts as a right shift.
    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        for (int i = 0; i < WIDTH; i++) begin
            y[i] = x[WIDTH-1-i];
        end
        return y;
    endfunction

endpackage

// File: rtl/my_shift_arbiter_shifter.sv
// Five-stage logarithmic left shifter with zero fill.
module my_32bit_barrelLeftShifter
    import my_shift_arbiter_pkg::*;
(
    input  logic [WIDTH-1:0]   data_input,
    input  logic [SHAMT_W-1:0] control_bits,
    output logic [WIDTH-1:0]   data_output
);

    logic [WIDTH-1:0] w_stage [0:SHAMT_W];

    assign w_stage[0] = data_input;

    // Stage k shifts by 2**k when control bit k is set.
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
        assign w_stage[gi+1] = control_bits[gi] ? (w_stage[gi] << (1 << gi)) : w_stage[gi];
    end

    assign data_output = w_stage[SHAMT_W];

endmodule

// File: rtl/my_shift_arbiter.sv
// Round-robin arbiter sharing one left barrel shifter between two requesters.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high on the same bit. Requesters hold req_valid and operands until
// their req_ready bit is seen; req_ready is only raised in IDLE. On the response
// side resp_valid[owner] and resp_data stay stable until resp_ready[owner] is
// high; resp_ready on the other bit has no effect.
module my_shift_arbiter
    import my_shift_arbiter_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [WIDTH-1:0]   req_data0,
    input  logic [SHAMT_W-1:0] req_shamt0,
    input  logic [1:0]         req_op0,
    input  logic [WIDTH-1:0]   req_data1,
    input  logic [SHAMT_W-1:0] req_shamt1,
    input  logic [1:0]         req_op1,
    output logic [1:0]         resp_valid,
    input  logic [1:0]         resp_ready,
    output logic [WIDTH-1:0]   resp_data,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_rr_ptr;
    logic               r_owner;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_shamt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_grant;
    logic               w_right;
    logic               w_invert;
    logic [WIDTH-1:0]   w_pre;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_post;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, grant selection and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_grant      = 1'b0;
        req_ready    = 2'b00;
        resp_valid   = 2'b00;
        case (r_state)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    w_accept     = 1'b1;
                    w_grant      = (req_valid == 2'b11) ? r_rr_ptr : req_valid[1];
                    req_ready    = w_grant ? 2'b10 : 2'b01;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                w_next_state = RESP;
            end
            RESP: begin
                resp_valid = r_owner ? 2'b10 : 2'b01;
                if (resp_ready[r_owner]) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Capture the granted operation and flip round-robin priority to the other requester.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
            r_data   <= '0;
            r_shamt  <= '0;
            r_op     <= OP_SLL;
        end else if (w_accept) begin
            r_rr_ptr <= ~w_grant;
            r_owner  <= w_grant;
            r_data   <= w_grant ? req_data1  : req_data0;
            r_shamt  <= w_grant ? req_shamt1 : req_shamt0;
            r_op     <= w_grant ? req_op1    : req_op0;
        end
    end

    // Right shifts run through the left shifter on a mirrored word; SRA of a
    // negative value also inverts around the shift so the vacated bits fill with ones.
    assign w_right  = (r_op == OP_SRL) || (r_op == OP_SRA);
    assign w_invert = (r_op == OP_SRA) && r_data[WIDTH-1];
    assign w_pre    = w_right ? bit_rev(w_invert ? ~r_data : r_data) : r_data;
    assign w_post   = w_right ? (w_invert ? ~bit_rev(w_shifted) : bit_rev(w_shifted))
                              : w_shifted;

    my_32bit_barrelLeftShifter u_shifter (
        .data_input   (w_pre),
        .control_bits (r_shamt),
        .data_output  (w_shifted)
    );

    // Register the shifter output once per operation; it is held through RESP and afterwards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
        end else if (r_state == SHIFT) begin
            r_result <= w_post;
        end
    end

    assign resp_data = r_result;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_my_shift_arbiter.sv
// Self-checking bench for my_shift_arbiter with a behavioural shift/arbitration model.
module tb_my_shift_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_data0;
  logic [4:0]  req_shamt0;
  logic [1:0]  req_op0;
  logic [31:0] req_data1;
  logic [4:0]  req_shamt1;
  logic [1:0]  req_op1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // model state: which requester wins when both are valid
  logic pref;
  logic [31:0] exp_q[$];
  logic        own_q[$];

  my_shift_arbiter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data0  (req_data0),
    .req_shamt0 (req_shamt0),
    .req_op0    (req_op0),
    .req_data1  (req_data1),
    .req_shamt1 (req_shamt1),
    .req_op1    (req_op1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 500000)", $time);
    $fatal(1, "watchdog");
  end

  // reference model: plain arithmetic shifts
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] op);
    case (op)
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return d << s;
    endcase
  endfunction

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // driver tasks
  task automatic set_operands(input logic idx, input logic [31:0] d, input logic [4:0] s,
                              input logic [1:0] op);
    if (idx) begin
      req_data1 = d; req_shamt1 = s; req_op1 = op;
    end else begin
      req_data0 = d; req_shamt0 = s; req_op0 = op;
    end
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    set_operands(1'b0, 32'h0, 5'd0, 2'b00);
    set_operands(1'b1, 32'h0, 5'd0, 2'b00);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    pref = 1'b0;
  endtask

  // single uncontended operation, response taken immediately
  task automatic run_op(input logic idx, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] op, input string tag);
    logic [31:0] exp;
    exp = ref_shift(d, s, op);
    @(negedge clock);
    set_operands(idx, d, s, op);
    req_valid  = onehot(idx);
    resp_ready = onehot(idx);
    #1;
    n_checks++;
    if (req_ready !== onehot(idx)) begin
      n_errors++;
      $display("FAIL %s accept: req_ready=%b required %b", tag, req_ready, onehot(idx));
    end
    pref = ~idx;
    @(negedge clock);
    req_valid = 2'b00;
    #1;
    n_checks++;
    if (req_ready !== 2'b00 || busy !== 1'b1 || resp_valid !== 2'b00) begin
      n_errors++;
      $display("FAIL %s shift: req_ready=%b busy=%b resp_valid=%b required 00/1/00",
               tag, req_ready, busy, resp_valid);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (resp_valid !== onehot(idx) || resp_data !== exp) begin
      n_errors++;
      $display("FAIL %s resp: resp_valid=%b data=%h required %b %h",
               tag, resp_valid, resp_data, onehot(idx), exp);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00) begin
      n_errors++;
      $display("FAIL %s done: busy=%b resp_valid=%b required 0 00", tag, busy, resp_valid);
    end
    resp_ready = 2'b00;
  endtask

  // tests
  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_data !== 32'h0 ||
        busy !== 1'b0 || dbg_state !== 2'b00) begin
      n_errors++;
      $display("FAIL reset: ready=%b rvalid=%b data=%h busy=%b state=%b required 00 00 0 0 00",
               req_ready, resp_valid, resp_data, busy, dbg_state);
    end
  endtask

  task automatic test_directed();
    run_op(1'b0, 32'h0000_00F0, 5'd4, 2'b00, "sll_f0");
    run_op(1'b1, 32'h8000_0010, 5'd4, 2'b10, "sra_neg");
    run_op(1'b1, 32'h8000_0010, 5'd4, 2'b01, "srl_neg");
    run_op(1'b0, 32'h4000_0010, 5'd4, 2'b10, "sra_pos");
  endtask

  task automatic test_boundaries();
    for (int op = 0; op < 4; op++) begin
      run_op(op[0], 32'hDEAD_BEEF, 5'd0, op[1:0], "shamt0");
    end
    run_op(1'b1, 32'h8000_0000, 5'd31, 2'b10, "sra31");
    run_op(1'b0, 32'h8000_0000, 5'd31, 2'b01, "srl31");
    run_op(1'b1, 32'h0000_0001, 5'd31, 2'b11, "sll31");
  endtask

  task automatic test_back_to_back();
    int  grants;
    int  resps;
    logic exp_g;
    logic refresh;
    logic refresh_idx;
    apply_reset();
    exp_q.delete();
    own_q.delete();
    grants  = 0;
    resps   = 0;
    refresh = 1'b0;
    refresh_idx = 1'b0;
    @(negedge clock);
    set_operands(1'b0, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    set_operands(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int cyc = 0; cyc < 40 && resps < 4; cyc++) begin
      if (cyc != 0) @(negedge clock);
      if (refresh) begin
        set_operands(refresh_idx, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        refresh = 1'b0;
      end
      #1;
      n_checks++;
      if (resp_valid === 2'b11) begin
        n_errors++;
        $display("FAIL b2b both_resp: resp_valid=%b required not 11", resp_valid);
      end
      if (req_ready !== 2'b00) begin
        exp_g = pref;
        n_checks++;
        if (req_ready !== onehot(exp_g)) begin
          n_errors++;
          $display("FAIL b2b grant%0d: req_ready=%b required %b", grants, req_ready, onehot(exp_g));
        end
        if (exp_g) exp_q.push_back(ref_shift(req_data1, req_shamt1, req_op1));
        else       exp_q.push_back(ref_shift(req_data0, req_shamt0, req_op0));
        own_q.push_back(exp_g);
        pref        = ~exp_g;
        refresh     = 1'b1;
        refresh_idx = exp_g;
        grants++;
      end
      if (resp_valid !== 2'b00 && exp_q.size() > 0) begin
        n_checks++;
        if (resp_valid !== onehot(own_q[0]) || resp_data !== exp_q[0]) begin
          n_errors++;
          $display("FAIL b2b resp%0d: resp_valid=%b data=%h required %b %h",
                   resps, resp_valid, resp_data, onehot(own_q[0]), exp_q[0]);
        end
        void'(exp_q.pop_front());
        void'(own_q.pop_front());
        resps++;
        if (resps == 4) req_valid = 2'b00;
      end
    end
    n_checks++;
    if (resps != 4) begin
      n_errors++;
      $display("FAIL b2b count: responses=%0d required 4", resps);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b idle: busy=%b required 0", busy);
    end
    resp_ready = 2'b00;
  endtask

  task automatic test_stall();
    logic [31:0] exp0;
    logic [31:0] exp1;
    exp0 = ref_shift(32'h1234_5678, 5'd8, 2'b01);
    exp1 = ref_shift(32'hF000_000F, 5'd3, 2'b10);
    @(negedge clock);
    set_operands(1'b0, 32'h1234_5678, 5'd8, 2'b01);
    req_valid  = 2'b01;
    resp_ready = 2'b00;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errors++;
      $display("FAIL stall accept: req_ready=%b required 01", req_ready);
    end
    pref = 1'b1;
    @(negedge clock);
    set_operands(1'b1, 32'hF000_000F, 5'd3, 2'b10);
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_errors++;
      $display("FAIL stall shift_ready: req_ready=%b required 00", req_ready);
    end
    resp_ready = 2'b10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      #1;
      n_checks++;
      if (resp_valid !== 2'b01 || resp_data !== exp0 || req_ready !== 2'b00 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL stall hold%0d: rvalid=%b data=%h ready=%b busy=%b required 01 %h 00 1",
                 k, resp_valid, resp_data, req_ready, busy, exp0);
      end
    end
    @(negedge clock);
    resp_ready = 2'b01;
    #1;
    n_checks++;
    if (resp_valid !== 2'b01 || resp_data !== exp0) begin
      n_errors++;
      $display("FAIL stall release: rvalid=%b data=%h required 01 %h", resp_valid, resp_data, exp0);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00 || req_ready !== 2'b10) begin
      n_errors++;
      $display("FAIL stall next: busy=%b rvalid=%b ready=%b required 0 00 10",
               busy, resp_valid, req_ready);
    end
    pref = 1'b0;
    resp_ready = 2'b10;
    @(negedge clock);
    req_valid = 2'b00;
    @(negedge clock);
    #1;
    n_checks++;
    if (resp_valid !== 2'b10 || resp_data !== exp1) begin
      n_errors++;
      $display("FAIL stall second: rvalid=%b data=%h required 10 %h", resp_valid, resp_data, exp1);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL stall end: busy=%b required 0", busy);
    end
    resp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    @(negedge clock);
    set_operands(1'b0, 32'hCAFE_0001, 5'd5, 2'b00);
    set_operands(1'b1, 32'h0BAD_F00D, 5'd7, 2'b01);
    req_valid  = 2'b01;
    resp_ready = 2'b11;
    @(negedge clock);
    req_valid = 2'b00;
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid pre: busy=%b required 1", busy);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00) begin
      n_errors++;
      $display("FAIL rstmid async: busy=%b rvalid=%b required 0 00", busy, resp_valid);
    end
    pref = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      n_checks++;
      if (resp_valid !== 2'b00 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL rstmid quiet%0d: rvalid=%b busy=%b required 00 0", k, resp_valid, busy);
      end
    end
    exp = ref_shift(32'hCAFE_0001, 5'd5, 2'b00);
    @(negedge clock);
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errors++;
      $display("FAIL rstmid grant: req_ready=%b required 01", req_ready);
    end
    pref = 1'b1;
    @(negedge clock);
    req_valid = 2'b00;
    @(negedge clock);
    #1;
    n_checks++;
    if (resp_valid !== 2'b01 || resp_data !== exp) begin
      n_errors++;
      $display("FAIL rstmid resp: rvalid=%b data=%h required 01 %h", resp_valid, resp_data, exp);
    end
    @(negedge clock);
    resp_ready = 2'b00;
  endtask

  task automatic test_random();
    logic [1:0]  pat;
    logic        g;
    int          stall;
    logic [31:0] d;
    for (int it = 0; it < 40; it++) begin
      @(negedge clock);
      for (int r = 0; r < 2; r++) begin
        case ($urandom_range(0, 3))
          0:       d = 32'h8000_0000;
          1:       d = 32'hFFFF_FFFF;
          default: d = $urandom;
        endcase
        set_operands(r[0], d, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      end
      pat        = 2'($urandom_range(1, 3));
      req_valid  = pat;
      resp_ready = 2'b00;
      #1;
      g = (pat == 2'b11) ? pref : pat[1];
      n_checks++;
      if (req_ready !== onehot(g)) begin
        n_errors++;
        $display("FAIL rand%0d grant: req_ready=%b required %b (valid %b)", it, req_ready, onehot(g), pat);
      end
      if (g) exp_q.push_back(ref_shift(req_data1, req_shamt1, req_op1));
      else   exp_q.push_back(ref_shift(req_data0, req_shamt0, req_op0));
      pref = ~g;
      @(negedge clock);
      req_valid  = 2'b00;
      resp_ready = $urandom_range(0, 1) ? ~onehot(g) : 2'b00;
      stall = $urandom_range(0, 3);
      for (int k = 0; k <= stall; k++) begin
        @(negedge clock);
        if (k == stall) resp_ready = onehot(g) | 2'($urandom_range(0, 3));
        #1;
        n_checks++;
        if (resp_valid !== onehot(g) || resp_data !== exp_q[0]) begin
          n_errors++;
          $display("FAIL rand%0d resp: rvalid=%b data=%h required %b %h",
                   it, resp_valid, resp_data, onehot(g), exp_q[0]);
        end
      end
      void'(exp_q.pop_front());
      @(negedge clock);
      #1;
      n_checks++;
      if (busy !== 1'b0 || resp_valid !== 2'b00) begin
        n_errors++;
        $display("FAIL rand%0d done: busy=%b rvalid=%b required 0 00", it, busy, resp_valid);
      end
      resp_ready = 2'b00;
    end
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
